// File: rtl/sdram_cmd_interface.sv
// SDRAM host command decode, power-up init sequencer and refresh scheduler.
// Define REF_POSTPONE_EN to count postponed refreshes (up to PEND_MAX) instead of a single request.
module sdram_cmd_interface #(
  parameter int ADDR_W    = 23,
  parameter int INIT_PER  = 24000,
  parameter int INIT_GAP  = 20,
  parameter int INIT_REFS = 8,
  parameter int REF_PER   = 1024,
  parameter int PEND_MAX  = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [2:0]        CMD,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              REF_ACK,
  input  logic              CM_ACK,
  output logic              NOP,
  output logic              READA,
  output logic              WRITEA,
  output logic [ADDR_W-1:0] SADDR,
  output logic              PRECHARGE,
  output logic              REFRESH,
  output logic              LOAD_MODE,
  output logic              INIT_REQ,
  output logic              INIT_DONE,
  output logic              REF_REQ,
  output logic [2:0]        REF_PEND,
  output logic              REF_OVF,
  output logic              CMD_ACK
);

  localparam int CNT_MAX = (INIT_PER > INIT_GAP) ? INIT_PER : INIT_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(INIT_PER - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(INIT_GAP - 1);
  localparam logic [3:0]       REFS_LAST  = 4'(INIT_REFS - 1);
  localparam logic [15:0]      REF_RELOAD = 16'(REF_PER);

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_PRE  = 3'd1,
    ST_REF  = 3'd2,
    ST_LMR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       refs_r;
  logic [15:0]      timer_r;
  logic             tick_s;
  logic             ack_s;
  logic             reload_s;

  // Init sequencer: every step waits out its gap, then emits a one-cycle command pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= ST_WAIT;
      cnt_r     <= '0;
      refs_r    <= 4'd0;
      INIT_REQ  <= 1'b1;
      INIT_DONE <= 1'b0;
      PRECHARGE <= 1'b0;
      REFRESH   <= 1'b0;
      LOAD_MODE <= 1'b0;
    end else begin
      PRECHARGE <= 1'b0;
      REFRESH   <= 1'b0;
      LOAD_MODE <= 1'b0;
      cnt_r     <= cnt_r + CNT_W'(1);
      case (state_r)
        ST_WAIT: begin
          if (cnt_r == PER_LAST) begin
            INIT_REQ <= 1'b0;
            cnt_r    <= '0;
            state_r  <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (cnt_r == GAP_LAST) begin
            PRECHARGE <= 1'b1;
            cnt_r     <= '0;
            state_r   <= ST_REF;
          end
        end
        ST_REF: begin
          if (cnt_r == GAP_LAST) begin
            REFRESH <= 1'b1;
            cnt_r   <= '0;
            refs_r  <= refs_r + 4'd1;
            if (refs_r == REFS_LAST) begin
              state_r <= ST_LMR;
            end
          end
        end
        ST_LMR: begin
          if (cnt_r == GAP_LAST) begin
            LOAD_MODE <= 1'b1;
            cnt_r     <= '0;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          INIT_DONE <= 1'b1;
          cnt_r     <= '0;
        end
        default: begin
          state_r <= ST_WAIT;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Host command decode and acknowledge; reads/writes are blocked until init completes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      NOP     <= 1'b0;
      READA   <= 1'b0;
      WRITEA  <= 1'b0;
      SADDR   <= '0;
      CMD_ACK <= 1'b0;
    end else begin
      NOP     <= (CMD == 3'b000);
      READA   <= INIT_DONE && (CMD == 3'b001);
      WRITEA  <= INIT_DONE && (CMD == 3'b010);
      SADDR   <= ADDR;
      CMD_ACK <= CM_ACK && !CMD_ACK;
    end
  end

  assign tick_s = INIT_DONE && (timer_r == 16'd0);
  assign ack_s  = INIT_DONE && REF_ACK;

`ifdef REF_POSTPONE_EN
  localparam logic [2:0] PEND_LIM = 3'(PEND_MAX);

  logic [2:0] pend_next_s;
  logic       ovf_set_s;
  logic       ack_eff_s;

  assign reload_s  = !INIT_DONE || tick_s;
  assign ack_eff_s = ack_s && (REF_PEND != 3'd0);

  // Postponed-refresh bookkeeping; a simultaneous tick and ack cancel out.
  always_comb begin
    pend_next_s = REF_PEND;
    ovf_set_s   = 1'b0;
    if (tick_s && !ack_eff_s) begin
      if (REF_PEND == PEND_LIM) begin
        ovf_set_s = 1'b1;
      end else begin
        pend_next_s = REF_PEND + 3'd1;
      end
    end else if (ack_eff_s && !tick_s) begin
      pend_next_s = REF_PEND - 3'd1;
    end else begin
      pend_next_s = REF_PEND;
    end
  end

  // Pending count, request and sticky overflow update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      REF_PEND <= 3'd0;
      REF_REQ  <= 1'b0;
      REF_OVF  <= 1'b0;
    end else begin
      REF_PEND <= pend_next_s;
      REF_REQ  <= (pend_next_s != 3'd0);
      REF_OVF  <= REF_OVF || ovf_set_s;
    end
  end
`else
  logic pend_max_unused_s;

  assign pend_max_unused_s = (PEND_MAX != 0);
  // An accepted refresh restarts the interval so the next request is a full period away.
  assign reload_s          = !INIT_DONE || tick_s || ack_s;

  // Single outstanding request; ack wins over a same-cycle tick.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      REF_REQ <= 1'b0;
    end else if (ack_s) begin
      REF_REQ <= 1'b0;
    end else if (tick_s) begin
      REF_REQ <= 1'b1;
    end
  end

  assign REF_PEND = {2'b00, REF_REQ};
  assign REF_OVF  = 1'b0;
`endif

  // Refresh interval timer, parked at its reload value until init completes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      timer_r <= REF_RELOAD;
    end else if (reload_s) begin
      timer_r <= REF_RELOAD;
    end else begin
      timer_r <= timer_r - 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_interface.sv
// Scoreboard bench for sdram_cmd_interface: expected events queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_sdram_cmd_interface;

  localparam int ADDR_W    = 23;
  localparam int INIT_PER  = 4;
  localparam int INIT_GAP  = 5;
  localparam int INIT_REFS = 3;
  localparam int REF_PER   = 16;
  localparam int PEND_MAX  = 4;

  logic              CLK     = 1'b0;
  logic              RESET_N = 1'b0;
  logic [2:0]        CMD     = 3'b000;
  logic [ADDR_W-1:0] ADDR    = '0;
  logic              REF_ACK = 1'b0;
  logic              CM_ACK  = 1'b0;
  logic              NOP, READA, WRITEA, PRECHARGE, REFRESH, LOAD_MODE;
  logic              INIT_REQ, INIT_DONE, REF_REQ, REF_OVF, CMD_ACK;
  logic [ADDR_W-1:0] SADDR;
  logic [2:0]        REF_PEND;

  sdram_cmd_interface #(
    .ADDR_W(ADDR_W), .INIT_PER(INIT_PER), .INIT_GAP(INIT_GAP),
    .INIT_REFS(INIT_REFS), .REF_PER(REF_PER), .PEND_MAX(PEND_MAX)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD(CMD), .ADDR(ADDR), .REF_ACK(REF_ACK), .CM_ACK(CM_ACK),
    .NOP(NOP), .READA(READA), .WRITEA(WRITEA), .SADDR(SADDR), .PRECHARGE(PRECHARGE),
    .REFRESH(REFRESH), .LOAD_MODE(LOAD_MODE), .INIT_REQ(INIT_REQ), .INIT_DONE(INIT_DONE),
    .REF_REQ(REF_REQ), .REF_PEND(REF_PEND), .REF_OVF(REF_OVF), .CMD_ACK(CMD_ACK)
  );

  always #5 CLK = ~CLK;

  typedef enum int {
    K_REQ = 0, K_PRE = 1, K_REF = 2, K_LMR = 3, K_DONE = 4, K_READA = 5,
    K_WRITEA = 6, K_ACK = 7, K_REFREQ = 8, K_PEND = 9, K_OVF = 10
  } kind_t;

  typedef struct {
    kind_t kind;
    int    cyc;
    int    val;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  // Rising edges since reset release; edge 1 is the first edge with RESET_N high.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic string kname(kind_t k);
    case (k)
      K_REQ:    return "init_req";
      K_PRE:    return "precharge";
      K_REF:    return "refresh";
      K_LMR:    return "load_mode";
      K_DONE:   return "init_done";
      K_READA:  return "reada";
      K_WRITEA: return "writea";
      K_ACK:    return "cmd_ack";
      K_REFREQ: return "ref_req";
      K_PEND:   return "ref_pend";
      K_OVF:    return "ref_ovf";
      default:  return "unknown";
    endcase
  endfunction

  task automatic expect_ev(kind_t k, int c, int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic see(kind_t k, int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s at cyc=%0d got val=%0h required no event", kname(k), cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        failures++;
        $display("FAIL event_%s got %s@%0d val=%0h required %s@%0d val=%0h",
                 kname(e.kind), kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
      end
    end
  endtask

  task automatic check_val(string name, int got, int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic check_reset_state(string name);
    logic [13:0] got;
    got = {NOP, READA, WRITEA, PRECHARGE, REFRESH, LOAD_MODE, INIT_REQ, INIT_DONE,
           REF_REQ, REF_PEND, REF_OVF, CMD_ACK};
    check_val({name, "_outputs"}, int'(got), 32'h0000_0080);
    check_val({name, "_saddr"}, int'(SADDR), 32'h0000_0000);
  endtask

  task automatic wait_cyc(int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    if (cyc < n) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout got cyc=%0d required cyc=%0d", cyc, n);
    end
  endtask

  // Hand-computed init timing for INIT_PER=4, INIT_GAP=5, INIT_REFS=3.
  task automatic expect_init(bit full);
    expect_ev(K_REQ, 4, 0);
    expect_ev(K_PRE, 9, 0);
    expect_ev(K_REF, 14, 0);
    expect_ev(K_REF, 19, 0);
    expect_ev(K_REF, 24, 0);
    if (full) begin
      expect_ev(K_LMR, 29, 0);
      expect_ev(K_DONE, 30, 1);
    end
  endtask

  // Monitor: turn every output activity into an event and match it against the queue.
  initial begin
    logic p_req, p_done, p_refreq, p_ovf;
    logic [2:0] p_pend;
    p_req = 1'b1; p_done = 1'b0; p_refreq = 1'b0; p_ovf = 1'b0; p_pend = 3'd0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        p_req = 1'b1; p_done = 1'b0; p_refreq = 1'b0; p_ovf = 1'b0; p_pend = 3'd0;
      end else begin
        checks++;
        if (int'(PRECHARGE) + int'(REFRESH) + int'(LOAD_MODE) > 1) begin
          failures++;
          $display("FAIL init_pulse_exclusive at cyc=%0d got pre/ref/lmr=%b%b%b required at most one",
                   cyc, PRECHARGE, REFRESH, LOAD_MODE);
        end
        if (INIT_REQ != p_req)   see(K_REQ, int'(INIT_REQ));
        if (PRECHARGE)           see(K_PRE, 0);
        if (REFRESH)             see(K_REF, 0);
        if (LOAD_MODE)           see(K_LMR, 0);
        if (INIT_DONE != p_done) see(K_DONE, int'(INIT_DONE));
        if (READA)               see(K_READA, int'(SADDR));
        if (WRITEA)              see(K_WRITEA, int'(SADDR));
        if (CMD_ACK)             see(K_ACK, 0);
        if (REF_REQ != p_refreq) see(K_REFREQ, int'(REF_REQ));
        if (REF_PEND != p_pend)  see(K_PEND, int'(REF_PEND));
        if (REF_OVF != p_ovf)    see(K_OVF, int'(REF_OVF));
        p_req = INIT_REQ; p_done = INIT_DONE; p_refreq = REF_REQ; p_ovf = REF_OVF; p_pend = REF_PEND;
      end
    end
  end

  // Stimulus.
  initial begin
    int end_cyc;
    repeat (3) @(negedge CLK);
    check_reset_state("por");

    expect_init(1'b1);
    expect_ev(K_READA, 33, 32'h0001_2345);
    expect_ev(K_WRITEA, 35, 32'h0007_ABCD);
    expect_ev(K_ACK, 37, 0);
    expect_ev(K_ACK, 39, 0);
`ifdef REF_POSTPONE_EN
    expect_ev(K_REFREQ, 47, 1);
    expect_ev(K_PEND, 47, 1);
    expect_ev(K_PEND, 64, 2);
    expect_ev(K_PEND, 81, 3);
    expect_ev(K_PEND, 98, 4);
    expect_ev(K_OVF, 115, 1);
    expect_ev(K_PEND, 118, 3);
    expect_ev(K_PEND, 120, 2);
    expect_ev(K_PEND, 122, 1);
    expect_ev(K_REFREQ, 124, 0);
    expect_ev(K_PEND, 124, 0);
    end_cyc = 126;
`else
    expect_ev(K_REFREQ, 47, 1);
    expect_ev(K_PEND, 47, 1);
    expect_ev(K_REFREQ, 51, 0);
    expect_ev(K_PEND, 51, 0);
    expect_ev(K_REFREQ, 68, 1);
    expect_ev(K_PEND, 68, 1);
    end_cyc = 70;
`endif

    @(negedge CLK);
    RESET_N = 1'b1;
    // Read and refresh ack before init is done must have no effect.
    CMD = 3'b001; ADDR = 23'h12345; REF_ACK = 1'b1;
    wait_cyc(1);
    CMD = 3'b000; ADDR = '0; REF_ACK = 1'b0;
    check_val("pre_init_reada", int'(READA), 0);
    check_val("nop_on_reada_cmd", int'(NOP), 0);
    wait_cyc(2);
    check_val("nop_decode", int'(NOP), 1);

    wait_cyc(32);
    CMD = 3'b001; ADDR = 23'h12345;
    wait_cyc(33);
    CMD = 3'b000; ADDR = '0;
    wait_cyc(34);
    CMD = 3'b010; ADDR = 23'h7ABCD;
    wait_cyc(35);
    CMD = 3'b000; ADDR = '0;
    wait_cyc(36);
    CM_ACK = 1'b1;
    wait_cyc(40);
    CM_ACK = 1'b0;

`ifdef REF_POSTPONE_EN
    for (int i = 0; i < 4; i++) begin
      wait_cyc(117 + 2 * i);
      REF_ACK = 1'b1;
      wait_cyc(118 + 2 * i);
      REF_ACK = 1'b0;
    end
`else
    wait_cyc(50);
    REF_ACK = 1'b1;
    wait_cyc(51);
    REF_ACK = 1'b0;
`endif
    wait_cyc(end_cyc);
    #2 RESET_N = 1'b0;
    #1 check_reset_state("reset_after_run");

    // Reset while the third init refresh pulse is high, then rerun the whole sequence.
    repeat (2) @(negedge CLK);
    expect_init(1'b0);
    RESET_N = 1'b1;
    wait_cyc(24);
    #2 RESET_N = 1'b0;
    #1 check_reset_state("reset_mid_init");
    repeat (2) @(negedge CLK);
    expect_init(1'b1);
    expect_ev(K_REFREQ, 47, 1);
    expect_ev(K_PEND, 47, 1);
    RESET_N = 1'b1;
    wait_cyc(49);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d left required 0 (next %s@%0d)",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
